// File: rtl/lane_serializer.sv
// lane_serializer: buffers 32-bit lane words in a 2-deep FIFO and sends them MSB first, filling gaps with K28.5 idle symbols.
// Ports:
//   clk_2f    - rising-edge clock for all state
//   reset     - asynchronous active-low reset
//   lane      - 32-bit word from one stripe lane
//   valid_in  - lane carries a word this cycle
//   ready     - a word offered this cycle will be stored
//   data_out  - registered serial bit
//   valid_out - registered, data_out is a payload bit
//   overflow  - sticky, a word was offered while ready was low
module lane_serializer (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [31:0] lane,
  input  logic        valid_in,
  output logic        ready,
  output logic        data_out,
  output logic        valid_out,
  output logic        overflow
);
  localparam logic [7:0] IDLE_SYM = 8'hBC;
  typedef enum logic {IDLE, SEND} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  count_q, count_d;
  logic        wptr_q, rptr_q;
  logic [31:0] mem_q [2];
  logic [31:0] shift_q, shift_d;
  logic        data_q, data_d, valid_q, valid_d, ovf_q;
  logic        push, pop, last;
  assign ready     = reset && (count_q < 2'd2);
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign overflow  = ovf_q;
  // pop only at the last bit of a symbol, judged on the count before this edge's push
  always_comb begin
    push    = valid_in && ready;
    last    = (state_q == IDLE) ? (cnt_q == 5'd7) : (cnt_q == 5'd31);
    pop     = last && (count_q != 2'd0);
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    state_d = pop ? SEND : (last ? IDLE : state_q);
    cnt_d   = last ? 5'd0 : cnt_q + 5'd1;
    shift_d = pop ? mem_q[rptr_q] : shift_q;
    data_d  = (state_q == IDLE) ? IDLE_SYM[3'd7 - cnt_q[2:0]] : shift_q[5'd31 - cnt_q];
    valid_d = (state_q == SEND);
  end
  always_ff @(posedge clk_2f) begin
    if (push) mem_q[wptr_q] <= lane;
  end
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      shift_q <= 32'd0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      wptr_q  <= wptr_q ^ push;
      rptr_q  <= rptr_q ^ pop;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_q | (valid_in & ~ready);
    end
  end
endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: random and directed stimulus against a bit-stream reference model with a word scoreboard.
module tb_lane_serializer;
  logic        clk_2f = 1'b0;
  logic        reset;
  logic [31:0] lane;
  logic        valid_in;
  logic        ready, data_out, valid_out, overflow;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  idle_sym = 8'hBC;
  bit          bitq[$];
  bit          vq[$];
  logic [31:0] fifo[$];
  logic [31:0] expq[$];
  bit          m_data, m_valid, m_ovf;
  logic [31:0] acc;
  int          bits = 0;

  lane_serializer dut (
    .clk_2f(clk_2f), .reset(reset), .lane(lane), .valid_in(valid_in),
    .ready(ready), .data_out(data_out), .valid_out(valid_out), .overflow(overflow)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic load_idle();
    for (int i = 7; i >= 0; i--) begin bitq.push_back(idle_sym[i]); vq.push_back(1'b0); end
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin bitq.push_back(w[i]); vq.push_back(1'b1); end
  endtask

  // reference: the line is a stream of whole symbols; the next symbol is chosen
  // when the current one runs out, from the words held before this edge's push
  always @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      fifo.delete(); expq.delete(); bitq.delete(); vq.delete();
      load_idle();
      m_data = 0; m_valid = 0; m_ovf = 0;
    end else begin
      int n;
      n = fifo.size();
      m_data  = bitq.pop_front();
      m_valid = vq.pop_front();
      if (bitq.size() == 0) begin
        if (fifo.size() > 0) load_word(fifo.pop_front()); else load_idle();
      end
      if (valid_in) begin
        if (n < 2) begin fifo.push_back(lane); expq.push_back(lane); end
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk_2f) begin
    logic [3:0] got, exp;
    got = {ready, overflow, valid_out, data_out};
    exp = {reset && (fifo.size() < 2), m_ovf, m_valid, m_data};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cycle {ready,ovf,valid,data} got=%b exp=%b t=%0t", got, exp, $time);
    end
    if (!reset) bits = 0;
    else if (valid_out === 1'b1) begin
      acc = {acc[30:0], data_out};
      bits++;
      if (bits == 32) begin
        bits = 0;
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL word unexpected got=%h exp=none t=%0t", acc, $time);
        end else begin
          logic [31:0] w;
          w = expq.pop_front();
          if (acc !== w) begin
            failures++;
            $display("FAIL word got=%h exp=%h t=%0t", acc, w, $time);
          end
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] l);
    valid_in = v; lane = l;
    @(posedge clk_2f); #1;
    valid_in = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 32'd0);
  endtask

  task automatic do_reset();
    reset = 0;
    idle(2);
    reset = 1;
  endtask

  task automatic expect1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  initial begin
    reset = 1; valid_in = 0; lane = 0;
    #1 reset = 0;
    idle(3);
    reset = 1;
    idle(24);
    // single word pushed at edge 2
    do_reset();
    cyc(0, 0); cyc(1, 32'hA5A5_0F0F);
    idle(50);
    // three consecutive pushes, third dropped
    do_reset();
    cyc(0, 0); cyc(1, 32'h1234_5678); cyc(1, 32'h9ABC_DEF0); cyc(1, 32'hDEAD_BEEF);
    expect1("overflow_set", overflow, 1'b1);
    idle(80);
    expect1("overflow_sticky", overflow, 1'b1);
    // one word per 32 cycles, aligned with pops
    do_reset();
    cyc(0, 0);
    for (int i = 0; i < 5; i++) begin cyc(1, $urandom); idle(31); end
    expect1("overflow_clear", overflow, 1'b0);
    idle(40);
    // reset pulse in the middle of a word
    do_reset();
    cyc(0, 0); cyc(1, 32'hFFFF_FFFF); cyc(1, 32'hCAFE_F00D);
    idle(20);
    reset = 0;
    #1;
    expect1("rst_data", data_out, 1'b0);
    expect1("rst_valid", valid_out, 1'b0);
    expect1("rst_ready", ready, 1'b0);
    @(posedge clk_2f); #1;
    reset = 1;
    idle(90);
    // random lane words with random gaps
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 40));
      cyc(1, $urandom);
    end
    idle(150);
    // random traffic that may overflow
    do_reset();
    for (int i = 0; i < 200; i++) cyc(($urandom_range(0, 15) == 0), $urandom);
    idle(120);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL words_left got=%0d exp=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
